sdram_init_refresh_arbiter: RTL and testbench

Owns the SDRAM command bus: runs the power-up init sequence, then schedules periodic auto-refresh and grants the bus to the read/write access engine between refreshes. Sits between the access engine (AXI-facing command generator) and the SDRAM pins. All SDRAM pin outputs are registered here.

---
 rtl/sdram_pkg.sv | 52 +++++
 rtl/sdram_init_refresh_arbiter_if.sv | 31 +++
 rtl/sdram_refresh_timer.sv | 66 ++++++
 rtl/sdram_init_refresh_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sdram_init_refresh_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and pin-bundle helper
// for the init/refresh arbiter.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_t;

  typedef enum logic [3:0] {
    ST_INIT_WAIT = 4'd0,
    ST_INIT_PRE  = 4'd1,
    ST_INIT_REF1 = 4'd2,
    ST_INIT_REF2 = 4'd3,
    ST_INIT_MRS  = 4'd4,
    ST_IDLE      = 4'd5,
    ST_ACCESS    = 4'd6,
    ST_REF_PRE   = 4'd7,
    ST_REF_CMD   = 4'd8
  } state_t;

  // Address bit that selects "all banks" on a PRECHARGE.
  localparam int A10_BIT = 10;
  localparam logic [12:0] ADDR_ALL_BANKS = 13'(1 << A10_BIT);

  typedef struct packed {
    logic        cs_n;
    logic [2:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
  } pin_bus_t;

  // Chip select follows the command: deselected only for NOP.
  function automatic pin_bus_t f_pins(input logic [2:0] cmd, input logic [12:0] addr,
                                      input logic [1:0] ba);
    pin_bus_t p;
    p.cs_n = (cmd == CMD_NOP) ? 1'b1 : 1'b0;
    p.cmd  = cmd;
    p.addr = addr;
    p.ba   = ba;
    return p;
  endfunction

  localparam pin_bus_t PINS_NOP = pin_bus_t'({1'b1, 3'b111, 13'h0000, 2'b00});

endpackage

// File: rtl/sdram_init_refresh_arbiter_if.sv
// Access-engine handshake plus SDRAM pin bundle; slave is the arbiter side,
// master is the access-engine side.
interface sdram_init_refresh_arbiter_if;
  logic        acc_req;
  logic        acc_gnt;
  logic        acc_done;
  logic [2:0]  acc_cmd;
  logic [12:0] acc_addr;
  logic [1:0]  acc_ba;
  logic        refresh_pending;
  logic        init_done;
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;

  modport slave (
    input  acc_req, acc_done, acc_cmd, acc_addr, acc_ba,
    output acc_gnt, refresh_pending, init_done,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_ba
  );

  modport master (
    output acc_req, acc_done, acc_cmd, acc_addr, acc_ba,
    input  acc_gnt, refresh_pending, init_done,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_ba
  );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer and saturating count of owed refreshes; the timer
// only runs once init has completed.
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_PENDING      = 8,
  localparam int PW              = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  input  logic          i_ref_done,
  output logic          o_tick,
  output logic [PW-1:0] o_count,
  output logic          o_pending
);
  localparam int TW = $clog2(REFRESH_INTERVAL + 1);

  logic [TW-1:0] r_tmr;
  logic [PW-1:0] r_count;
  logic          r_pending;
  logic          w_tick;
  logic [PW-1:0] w_count_nxt;

  assign w_tick = i_run && (r_tmr == TW'(REFRESH_INTERVAL - 1));

  // A tick and a completion in the same cycle cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_tick && !i_ref_done) begin
      if (r_count != PW'(MAX_PENDING)) begin
        w_count_nxt = r_count + PW'(1);
      end else begin
        w_count_nxt = r_count;
      end
    end else if (i_ref_done && !w_tick) begin
      if (r_count != '0) begin
        w_count_nxt = r_count - PW'(1);
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmr     <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!i_run || w_tick) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + TW'(1);
      end
      r_count   <= w_count_nxt;
      r_pending <= (w_count_nxt != '0);
    end
  end

  assign o_tick    = w_tick;
  assign o_count   = r_count;
  assign o_pending = r_pending;

endmodule

// File: rtl/sdram_init_refresh_arbiter.sv
// SDRAM command-bus owner: power-up init sequence, periodic auto-refresh and
// hand-off of the bus to the access engine between refreshes.
module sdram_init_refresh_arbiter
  import sdram_pkg::*;
#(
  parameter int          INIT_WAIT_CYCLES = 20000,
  parameter int          REFRESH_INTERVAL = 780,
  parameter int          T_RP             = 2,
  parameter int          T_RC             = 7,
  parameter int          T_MRD            = 2,
  parameter logic [12:0] MODE_REG         = 13'h0030,
  parameter int          MAX_PENDING      = 8
) (
  input  logic clk,
  input  logic rst,
  sdram_init_refresh_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(INIT_WAIT_CYCLES + T_RP + T_RC + T_MRD + 1);
  localparam int PW    = $clog2(MAX_PENDING + 1);

  state_t        r_state;
  logic [CNT_W-1:0] r_wait;
  logic          r_cke;
  logic          r_gnt;
  logic          r_init_done;
  pin_bus_t      r_pins;

  logic          w_tick;
  logic [PW-1:0] w_count;
  logic          w_pending;
  logic          w_ref_done;
  logic          w_more_ref;

  assign w_ref_done = (r_state == ST_REF_CMD) && (r_wait == '0);
  // Count as it will stand after this completion: still owed if >1 or a tick lands now.
  assign w_more_ref = (w_count > PW'(1)) || w_tick;

  sdram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_run      (r_init_done),
    .i_ref_done (w_ref_done),
    .o_tick     (w_tick),
    .o_count    (w_count),
    .o_pending  (w_pending)
  );

  // r_wait counts down to zero; the next command issues on the edge that sees zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT_WAIT;
      r_wait      <= CNT_W'(INIT_WAIT_CYCLES - 1);
      r_cke       <= 1'b0;
      r_gnt       <= 1'b0;
      r_init_done <= 1'b0;
      r_pins      <= PINS_NOP;
    end else begin
      r_cke <= 1'b1;
      case (r_state)
        ST_INIT_WAIT: begin
          if (r_wait == '0) begin
            r_pins  <= f_pins(CMD_PRE, ADDR_ALL_BANKS, 2'b00);
            r_wait  <= CNT_W'(T_RP - 1);
            r_state <= ST_INIT_PRE;
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_INIT_PRE: begin
          if (r_wait == '0) begin
            r_pins  <= f_pins(CMD_REF, 13'h0000, 2'b00);
            r_wait  <= CNT_W'(T_RC - 1);
            r_state <= ST_INIT_REF1;
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_INIT_REF1: begin
          if (r_wait == '0) begin
            r_pins  <= f_pins(CMD_REF, 13'h0000, 2'b00);
            r_wait  <= CNT_W'(T_RC - 1);
            r_state <= ST_INIT_REF2;
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_INIT_REF2: begin
          if (r_wait == '0) begin
            r_pins  <= f_pins(CMD_MRS, MODE_REG, 2'b00);
            r_wait  <= CNT_W'(T_MRD - 1);
            r_state <= ST_INIT_MRS;
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_INIT_MRS: begin
          r_pins <= PINS_NOP;
          if (r_wait == '0) begin
            r_init_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (w_count != '0) begin
            r_pins  <= f_pins(CMD_PRE, ADDR_ALL_BANKS, 2'b00);
            r_wait  <= CNT_W'(T_RP - 1);
            r_state <= ST_REF_PRE;
          end else if (bus.acc_req) begin
            r_pins  <= PINS_NOP;
            r_gnt   <= 1'b1;
            r_state <= ST_ACCESS;
          end else begin
            r_pins <= PINS_NOP;
          end
        end
        ST_ACCESS: begin
          if (bus.acc_done) begin
            r_pins  <= PINS_NOP;
            r_gnt   <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_pins <= f_pins(bus.acc_cmd, bus.acc_addr, bus.acc_ba);
          end
        end
        ST_REF_PRE: begin
          if (r_wait == '0) begin
            r_pins  <= f_pins(CMD_REF, 13'h0000, 2'b00);
            r_wait  <= CNT_W'(T_RC - 1);
            r_state <= ST_REF_CMD;
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        ST_REF_CMD: begin
          // The arbitration decision is taken on the completion edge so passes stay T_RP+T_RC apart.
          if (r_wait == '0) begin
            if (w_more_ref) begin
              r_pins  <= f_pins(CMD_PRE, ADDR_ALL_BANKS, 2'b00);
              r_wait  <= CNT_W'(T_RP - 1);
              r_state <= ST_REF_PRE;
            end else if (bus.acc_req) begin
              r_pins  <= PINS_NOP;
              r_gnt   <= 1'b1;
              r_state <= ST_ACCESS;
            end else begin
              r_pins  <= PINS_NOP;
              r_state <= ST_IDLE;
            end
          end else begin
            r_pins <= PINS_NOP;
            r_wait <= r_wait - CNT_W'(1);
          end
        end
        default: begin
          r_pins      <= PINS_NOP;
          r_gnt       <= 1'b0;
          r_init_done <= 1'b0;
          r_wait      <= CNT_W'(INIT_WAIT_CYCLES - 1);
          r_state     <= ST_INIT_WAIT;
        end
      endcase
    end
  end

  assign bus.acc_gnt         = r_gnt;
  assign bus.init_done       = r_init_done;
  assign bus.refresh_pending = w_pending;
  assign bus.sdram_cke       = r_cke;
  assign bus.sdram_cs_n      = r_pins.cs_n;
  assign bus.sdram_ras_n     = r_pins.cmd[2];
  assign bus.sdram_cas_n     = r_pins.cmd[1];
  assign bus.sdram_we_n      = r_pins.cmd[0];
  assign bus.sdram_addr      = r_pins.addr;
  assign bus.sdram_ba        = r_pins.ba;

endmodule

// File: tb/tb_sdram_init_refresh_arbiter.sv
// Bench for sdram_init_refresh_arbiter: timestamp-based reference model checked
// every cycle, plus directed literal checks of init, saturation and reset.
module tb_sdram_init_refresh_arbiter;

  localparam int IW   = 10;
  localparam int TRP  = 2;
  localparam int TRC  = 4;
  localparam int TMRD = 2;
  localparam int RI   = 50;
  localparam int MAXP = 8;
  localparam logic [12:0] MODE = 13'h0030;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  sdram_init_refresh_arbiter_if u_if();

  sdram_init_refresh_arbiter #(
    .INIT_WAIT_CYCLES (IW),
    .REFRESH_INTERVAL (RI),
    .T_RP             (TRP),
    .T_RC             (TRC),
    .T_MRD            (TMRD),
    .MODE_REG         (MODE),
    .MAX_PENDING      (MAXP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset release plus timestamps of scheduled events.
  int   t;
  bit   m_init, m_gnt, m_idle;
  int   m_init_t, m_cnt, m_ref_t, m_done_t;
  logic e_cke, e_cs_n, e_gnt, e_init, e_pend;
  logic [2:0]  e_cmd;
  logic [12:0] e_addr;
  logic [1:0]  e_ba;

  task automatic set_pins(input logic [2:0] c, input logic [12:0] a, input logic [1:0] b);
    e_cmd  = c;
    e_cs_n = (c == 3'b111);
    e_addr = a;
    e_ba   = b;
  endtask

  task automatic model_reset();
    t = 0; m_init = 0; m_gnt = 0; m_idle = 0;
    m_init_t = 0; m_cnt = 0; m_ref_t = -1; m_done_t = -1;
    e_cke = 1'b0; e_gnt = 1'b0; e_init = 1'b0; e_pend = 1'b0;
    set_pins(3'b111, 13'h0000, 2'b00);
  endtask

  task automatic decide(input int c);
    m_idle = 0;
    if (c != 0) begin
      set_pins(3'b010, 13'h0400, 2'b00);
      m_ref_t  = t + TRP;
      m_done_t = t + TRP + TRC;
    end else if (u_if.acc_req) begin
      m_gnt = 1;
    end else begin
      m_idle = 1;
    end
  endtask

  task automatic model_step();
    bit tick, done;
    int c_before;
    t = t + 1;
    e_cke = 1'b1;
    set_pins(3'b111, 13'h0000, 2'b00);
    if (!m_init) begin
      if (t == IW)                        set_pins(3'b010, 13'h0400, 2'b00);
      else if (t == IW + TRP)             set_pins(3'b001, 13'h0000, 2'b00);
      else if (t == IW + TRP + TRC)       set_pins(3'b001, 13'h0000, 2'b00);
      else if (t == IW + TRP + 2*TRC)     set_pins(3'b000, MODE, 2'b00);
      else if (t == IW + TRP + 2*TRC + TMRD) begin
        m_init = 1; m_init_t = t; m_idle = 1;
      end
    end else begin
      tick = (t > m_init_t) && (((t - m_init_t) % RI) == 0);
      done = (t == m_done_t);
      c_before = m_cnt;
      if (tick && !done) m_cnt = (m_cnt < MAXP) ? m_cnt + 1 : MAXP;
      else if (done && !tick) m_cnt = m_cnt - 1;
      if (m_gnt) begin
        if (u_if.acc_done) begin
          m_gnt = 0; m_idle = 1;
        end else begin
          set_pins(u_if.acc_cmd, u_if.acc_addr, u_if.acc_ba);
        end
      end else if (t == m_ref_t) begin
        set_pins(3'b001, 13'h0000, 2'b00);
      end else if (done) begin
        decide(m_cnt);
      end else if (m_idle) begin
        decide(c_before);
      end
    end
    e_init = m_init;
    e_gnt  = m_gnt;
    e_pend = (m_cnt != 0);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  logic [22:0] act_v, exp_v;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      act_v = {u_if.sdram_cke, u_if.sdram_cs_n, u_if.sdram_ras_n, u_if.sdram_cas_n,
               u_if.sdram_we_n, u_if.sdram_addr, u_if.sdram_ba, u_if.acc_gnt,
               u_if.init_done, u_if.refresh_pending};
      exp_v = {e_cke, e_cs_n, e_cmd, e_addr, e_ba, e_gnt, e_init, e_pend};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL cycle t=%0d actual=%h required=%h", t, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic rand_bus();
    u_if.acc_cmd  = 3'($urandom_range(0, 7));
    u_if.acc_addr = 13'($urandom);
    u_if.acc_ba   = 2'($urandom);
  endtask

  function automatic logic [3:0] pins_cmd();
    return {u_if.sdram_cs_n, u_if.sdram_ras_n, u_if.sdram_cas_n, u_if.sdram_we_n};
  endfunction

  int  refs, last_ref;
  bit  found;
  logic pend_577, pend_578;

  initial begin
    u_if.acc_req = 1'b0; u_if.acc_done = 1'b0;
    u_if.acc_cmd = 3'b111; u_if.acc_addr = 13'h0000; u_if.acc_ba = 2'b00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_pins", {u_if.sdram_cke, pins_cmd(), u_if.sdram_addr, u_if.sdram_ba}, {1'b0, 4'b1111, 13'h0, 2'b0});
    chk("reset_flags", {u_if.acc_gnt, u_if.init_done, u_if.refresh_pending}, 3'b000);
    rst = 1'b1;

    // Power-up sequence with literal timing expectations.
    @(negedge clk);
    chk("cke_first", u_if.sdram_cke, 1'b1);
    while (t < 10) @(negedge clk);
    chk("init_pre", {pins_cmd(), u_if.sdram_addr[10]}, {4'b0010, 1'b1});
    while (t < 12) @(negedge clk);
    chk("init_ref1", pins_cmd(), 4'b0001);
    while (t < 16) @(negedge clk);
    chk("init_ref2", pins_cmd(), 4'b0001);
    while (t < 20) @(negedge clk);
    chk("init_mrs", {pins_cmd(), u_if.sdram_addr}, {4'b0000, 13'h0030});
    while (t < 21) @(negedge clk);
    chk("init_done_21", u_if.init_done, 1'b0);
    while (t < 22) @(negedge clk);
    chk("init_done_22", u_if.init_done, 1'b1);

    // First access: grant next cycle, pins follow with one cycle latency.
    u_if.acc_req = 1'b1;
    @(negedge clk);
    chk("gnt_23", u_if.acc_gnt, 1'b1);
    u_if.acc_cmd = 3'b101; u_if.acc_addr = 13'h0123; u_if.acc_ba = 2'b10;
    @(negedge clk);
    chk("acc_pins_24", {pins_cmd(), u_if.sdram_addr, u_if.sdram_ba}, {4'b0101, 13'h0123, 2'b10});

    // Hold the bus long enough to saturate the owed-refresh count.
    while (t < 522) begin
      @(negedge clk);
      rand_bus();
    end
    chk("pend_held", u_if.refresh_pending, 1'b1);
    u_if.acc_done = 1'b1; u_if.acc_req = 1'b0;
    @(negedge clk);
    u_if.acc_done = 1'b0;
    chk("gnt_drop", {u_if.acc_gnt, pins_cmd()}, {1'b0, 4'b1111});
    refs = 0; last_ref = 0; pend_577 = 1'b0; pend_578 = 1'b1;
    while (t < 600) begin
      @(negedge clk);
      if (pins_cmd() == 4'b0001) begin refs++; last_ref = t; end
      if (t == 577) pend_577 = u_if.refresh_pending;
      if (t == 578) pend_578 = u_if.refresh_pending;
    end
    chk("drain_refs", refs, 9);
    chk("drain_last_ref", last_ref, 574);
    chk("drain_pend_577", pend_577, 1'b1);
    chk("drain_pend_578", pend_578, 1'b0);

    // Randomized traffic with idle gaps so ticks meet both idle and busy buses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rand_bus();
      if ((i % 400) < 60) u_if.acc_req = 1'b0;
      else                u_if.acc_req = ($urandom_range(0, 3) != 0);
      if (u_if.acc_gnt) u_if.acc_done = ($urandom_range(0, 11) == 0);
      else              u_if.acc_done = ($urandom_range(0, 5) == 0);
    end

    // Asynchronous reset in the middle of an access.
    u_if.acc_req = 1'b1; u_if.acc_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (u_if.acc_gnt) found = 1'b1;
    end
    chk("gnt_before_reset", found, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_pins", {u_if.sdram_cke, pins_cmd(), u_if.sdram_addr, u_if.sdram_ba}, {1'b0, 4'b1111, 13'h0, 2'b0});
    chk("async_flags", {u_if.acc_gnt, u_if.init_done, u_if.refresh_pending}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    while (t < 10) begin
      @(negedge clk);
      rand_bus();
    end
    chk("reinit_pre", {pins_cmd(), u_if.sdram_addr[10]}, {4'b0010, 1'b1});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_bus();
      u_if.acc_req = ($urandom_range(0, 1) != 0);
      u_if.acc_done = u_if.acc_gnt && ($urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
